// File: rtl/line_pingpong_buffer.sv
// Ping-pong camera line buffer: fills two line RAMs alternately and streams each completed line
// over valid/ready. Optional LINE_TAG_EN adds outLineNum, a per-frame line counter.
module line_pingpong_buffer #(
   parameter int unsigned LINE_PIXELS = 640,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic              camPCLK,
   input  logic              resetN,
   input  logic              camVSYNC,
   input  logic [15:0]       pixIn,
   input  logic              buffClear1,
   input  logic              buffClear2,
   input  logic              writeBuff1,
   input  logic              writeBuff2,
   input  logic              buffSelect,
   output logic [15:0]       outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              outLast,
   output logic              outFrameStart,
`ifdef LINE_TAG_EN
   output logic [ADDR_W-1:0] outLineNum,
`endif
   output logic              overflow
);

   typedef enum logic [1:0] {RamEmpty, RamFilling, RamFull} ramState_e;
   typedef enum logic [1:0] {RdIdle, RdPrime, RdStream, RdDone} rdState_e;

   localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(LINE_PIXELS);

   ramState_e         ramStateQ [2];
   ramState_e         ramStateD [2];
   logic [ADDR_W-1:0] wrAddrQ [2];
   logic [ADDR_W-1:0] wrAddrD [2];
   logic [ADDR_W-1:0] lenQ [2];
   logic [ADDR_W-1:0] lenD [2];
   logic [1:0]        clr, wr, we, lineDone, ovf;

   rdState_e          rdStateQ, rdStateD;
   logic              rdPtrQ, rdPtrD;
   logic [ADDR_W-1:0] rdAddrQ, rdAddrD, rdIdx;
   logic              selPrevQ, frameFirstQ, frameFirstD, lineFirstQ, lineFirstD, overflowQ;
   logic              toggle, handshake, lastBeat, streaming, abort;

   logic [15:0]       mem1 [LINE_PIXELS];
   logic [15:0]       mem2 [LINE_PIXELS];
   logic [15:0]       rdData1, rdData2;

   assign clr           = {buffClear2, buffClear1};
   assign wr            = {writeBuff2, writeBuff1};
   assign toggle        = (buffSelect != selPrevQ) && !camVSYNC;
   assign outValid      = (rdStateQ == RdStream);
   assign handshake     = outValid && outReady;
   assign lastBeat      = outValid && (rdAddrQ == lenQ[rdPtrQ] - ADDR_W'(1));
   assign streaming     = (rdStateQ == RdPrime) || (rdStateQ == RdStream);
   assign abort         = streaming && ovf[rdPtrQ];
   assign outData       = rdPtrQ ? rdData2 : rdData1;
   assign outLast       = lastBeat;
   assign outFrameStart = outValid && lineFirstQ && (rdAddrQ == '0);
   assign overflow      = overflowQ;
   assign frameFirstD   = camVSYNC ? 1'b1 : (rdStateQ == RdDone) ? 1'b0 : frameFirstQ;

   for (genvar g = 0; g < 2; g++) begin : gRam
      assign we[g] = wr[g] && !clr[g] && (ramStateQ[g] == RamFilling) && (wrAddrQ[g] < MaxAddr);
      // Accepting the final beat frees the RAM, so a clear landing on that same edge is legal.
      assign lineDone[g] = handshake && lastBeat && (rdPtrQ == 1'(g));
      assign ovf[g]      = clr[g] && (ramStateQ[g] == RamFull) && !lineDone[g];
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ramStateD[i] = ramStateQ[i];
         wrAddrD[i]   = wrAddrQ[i];
         lenD[i]      = lenQ[i];
         if (we[i]) wrAddrD[i] = wrAddrQ[i] + ADDR_W'(1);
         if (camVSYNC && (ramStateQ[i] == RamFilling)) ramStateD[i] = RamEmpty;
         if (toggle && (selPrevQ == 1'(i)) && (ramStateQ[i] == RamFilling)) begin
            lenD[i]      = wrAddrQ[i];
            ramStateD[i] = (wrAddrQ[i] == '0) ? RamEmpty : RamFull;
         end
         if (lineDone[i]) ramStateD[i] = RamEmpty;
         if (clr[i]) begin
            ramStateD[i] = RamFilling;
            wrAddrD[i]   = '0;
         end
      end
   end

   always_comb begin
      rdStateD   = rdStateQ;
      rdPtrD     = rdPtrQ;
      rdAddrD    = rdAddrQ;
      rdIdx      = rdAddrQ;
      lineFirstD = lineFirstQ;
      unique case (rdStateQ)
         RdIdle: begin
            // A dropped or empty line breaks strict alternation; fall back to the other RAM.
            if (ramStateQ[rdPtrQ] == RamFull) begin
               rdStateD = RdPrime;
               rdAddrD  = '0;
            end else if (ramStateQ[!rdPtrQ] == RamFull) begin
               rdStateD = RdPrime;
               rdAddrD  = '0;
               rdPtrD   = !rdPtrQ;
            end
         end
         RdPrime: begin
            lineFirstD = frameFirstQ;
            rdStateD   = RdStream;
         end
         RdStream: begin
            if (handshake) begin
               if (lastBeat) begin
                  rdStateD = RdDone;
               end else begin
                  rdAddrD = rdAddrQ + ADDR_W'(1);
                  rdIdx   = rdAddrD;
               end
            end
         end
         RdDone: begin
            rdStateD = RdIdle;
            rdPtrD   = !rdPtrQ;
         end
         default: rdStateD = RdIdle;
      endcase
      if (abort) rdStateD = RdIdle;
   end

   always_ff @(posedge camPCLK) begin
      if (!resetN) begin
         for (int i = 0; i < 2; i++) begin
            ramStateQ[i] <= RamEmpty;
            wrAddrQ[i]   <= '0;
            lenQ[i]      <= '0;
         end
         rdStateQ    <= RdIdle;
         rdPtrQ      <= 1'b0;
         rdAddrQ     <= '0;
         frameFirstQ <= 1'b1;
         lineFirstQ  <= 1'b0;
         overflowQ   <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            ramStateQ[i] <= ramStateD[i];
            wrAddrQ[i]   <= wrAddrD[i];
            lenQ[i]      <= lenD[i];
         end
         rdStateQ    <= rdStateD;
         rdPtrQ      <= rdPtrD;
         rdAddrQ     <= rdAddrD;
         frameFirstQ <= frameFirstD;
         lineFirstQ  <= lineFirstD;
         overflowQ   <= overflowQ | (|ovf);
      end
      selPrevQ <= buffSelect;
   end

   always_ff @(posedge camPCLK) begin
      if (we[0]) mem1[wrAddrQ[0]] <= pixIn;
      rdData1 <= mem1[rdIdx];
   end

   always_ff @(posedge camPCLK) begin
      if (we[1]) mem2[wrAddrQ[1]] <= pixIn;
      rdData2 <= mem2[rdIdx];
   end

`ifdef LINE_TAG_EN
   logic [ADDR_W-1:0] lineNumQ;

   always_ff @(posedge camPCLK) begin
      if (!resetN || camVSYNC) begin
         lineNumQ <= '0;
      end else if ((rdStateQ == RdDone) && (lineNumQ != '1)) begin
         lineNumQ <= lineNumQ + ADDR_W'(1);
      end
   end

   assign outLineNum = lineNumQ;
`endif

endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Bench for line_pingpong_buffer: directed line sequences with random pixels, checked against a
// queue model of whole lines (truncation, drops, frame-start, overflow abort).
module tb_line_pingpong_buffer;
   localparam int LinePix = 640;
   localparam int AddrW   = 10;

   logic             camPCLK = 1'b0;
   logic             resetN = 1'b0;
   logic             camVSYNC, buffClear1, buffClear2, writeBuff1, writeBuff2, buffSelect;
   logic [15:0]      pixIn, outData;
   logic             outValid, outReady, outLast, outFrameStart, overflow;
`ifdef LINE_TAG_EN
   logic [AddrW-1:0] outLineNum;
`endif

   line_pingpong_buffer #(.LINE_PIXELS(LinePix), .ADDR_W(AddrW)) dut (
      .camPCLK       (camPCLK),
      .resetN        (resetN),
      .camVSYNC      (camVSYNC),
      .pixIn         (pixIn),
      .buffClear1    (buffClear1),
      .buffClear2    (buffClear2),
      .writeBuff1    (writeBuff1),
      .writeBuff2    (writeBuff2),
      .buffSelect    (buffSelect),
      .outData       (outData),
      .outValid      (outValid),
      .outReady      (outReady),
      .outLast       (outLast),
      .outFrameStart (outFrameStart),
`ifdef LINE_TAG_EN
      .outLineNum    (outLineNum),
`endif
      .overflow      (overflow)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        l;
      logic        f;
   } beat_t;

   beat_t       expQ[$];
   beat_t       obsQ[$];
   logic [15:0] curLine[$];
   int          total = 0, bad = 0, stabChecks = 0, stabBad = 0, readyMode = 0;
   logic        curSel = 1'b0, modelFF = 1'b1;
   logic        pValid = 1'b0, pReady = 1'b0;
   beat_t       pBeat = '0;

   initial forever #5 camPCLK = ~camPCLK;

   // readyMode: 0 always ready, 1 alternate, 2 hold off, 3 random
   initial begin
      outReady = 1'b1;
      forever begin
         @(posedge camPCLK);
         #1;
         case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = !outReady;
            2:       outReady = 1'b0;
            default: outReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge camPCLK) begin
      if (resetN) begin
         if (outValid && outReady) obsQ.push_back(beat_t'({outData, outLast, outFrameStart}));
         if (pValid && !pReady && outValid) begin
            stabChecks <= stabChecks + 1;
            if (pBeat != beat_t'({outData, outLast, outFrameStart})) stabBad <= stabBad + 1;
         end
      end
      pValid <= outValid && resetN;
      pReady <= outReady;
      pBeat  <= beat_t'({outData, outLast, outFrameStart});
   end

   task automatic tick();
      @(posedge camPCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic startLine();
      if (curSel) buffClear2 = 1'b1;
      else buffClear1 = 1'b1;
      tick();
      buffClear1 = 1'b0;
      buffClear2 = 1'b0;
      curLine.delete();
   endtask

   task automatic writePix(input int n, input bit useIndex);
      for (int k = 0; k < n; k++) begin
         pixIn = useIndex ? 16'(k) : 16'($urandom);
         if (curSel) writeBuff2 = 1'b1;
         else writeBuff1 = 1'b1;
         if (curLine.size() < LinePix) curLine.push_back(pixIn);
         tick();
      end
      writeBuff1 = 1'b0;
      writeBuff2 = 1'b0;
   endtask

   // Completing a line: every stored pixel becomes a beat; first line after VSYNC is flagged.
   task automatic endLine();
      buffSelect = !curSel;
      curSel     = !curSel;
      tick();
      for (int k = 0; k < curLine.size(); k++)
         expQ.push_back(beat_t'({curLine[k], k == curLine.size() - 1, (k == 0) && modelFF}));
      if (curLine.size() > 0) modelFF = 1'b0;
      curLine.delete();
   endtask

   task automatic vsyncPulse(input bit flipSel);
      camVSYNC = 1'b1;
      tick();
      if (flipSel) begin
         buffSelect = !buffSelect;
         curSel     = !curSel;
      end
      tick();
      tick();
      camVSYNC = 1'b0;
      tick();
      curLine.delete();
      modelFF = 1'b1;
   endtask

   task automatic expectFirst(input string tag);
      check({tag, "_lat0"}, outValid, 1'b0);
      tick();
      check({tag, "_lat1"}, outValid, 1'b0);
      tick();
      check({tag, "_valid"}, outValid, 1'b1);
      check({tag, "_fs"}, outFrameStart, 1'b1);
      check({tag, "_data0"}, outData, expQ[0].d);
   endtask

   task automatic drain(input string tag, input int mode);
      int n = 0;
      readyMode = mode;
      while ((obsQ.size() < expQ.size() || outValid) && n < 5000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check({tag, "_count"}, obsQ.size(), expQ.size());
      for (int k = 0; k < expQ.size() && k < obsQ.size(); k++) begin
         check({tag, "_data"}, obsQ[k].d, expQ[k].d);
         check({tag, "_last"}, obsQ[k].l, expQ[k].l);
         check({tag, "_fs"}, obsQ[k].f, expQ[k].f);
      end
      obsQ.delete();
      expQ.delete();
      readyMode = 0;
   endtask

   initial begin
      int    n1;
      logic  savedF;
      beat_t tmp;
      camVSYNC = 1'b0; pixIn = '0; buffSelect = 1'b0;
      buffClear1 = 1'b0; buffClear2 = 1'b0; writeBuff1 = 1'b0; writeBuff2 = 1'b0;
      repeat (3) tick();
      check("rst_valid", outValid, 1'b0);
      check("rst_last", outLast, 1'b0);
      check("rst_fs", outFrameStart, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      resetN = 1'b1;
      tick();

      vsyncPulse(1'b0);
      startLine(); writePix(640, 1'b1); endLine();
      expectFirst("full");
      drain("full", 0);

      vsyncPulse(1'b0);
      readyMode = 1;
      startLine(); writePix(4, 1'b0); endLine();
      startLine(); writePix(4, 1'b0); endLine();
      drain("pair", 1);

      startLine(); writePix(700, 1'b0); endLine();
      drain("long", 0);

      startLine(); endLine();
      startLine(); writePix(3, 1'b0); endLine();
      drain("zero", 3);

      for (int r = 0; r < 4; r++) begin
         startLine(); writePix(int'($urandom_range(1, 40)), 1'b0); endLine();
         drain("rand", 3);
      end

      startLine(); writePix(100, 1'b0);
      vsyncPulse(1'b1);
      startLine(); writePix(8, 1'b0); endLine();
      expectFirst("vsync");
`ifdef LINE_TAG_EN
      check("vsync_linenum", outLineNum, '0);
`endif
      drain("vsync", 0);
      check("ovf_clean", overflow, 1'b0);

      // Three lines against a stalled sink: the third clear hits the RAM being streamed.
      vsyncPulse(1'b0);
      readyMode = 2;
      tick(); tick();
      startLine(); writePix(6, 1'b0); endLine();
      n1     = expQ.size();
      savedF = expQ[0].f;
      startLine(); writePix(5, 1'b0); endLine();
      repeat (3) tick();
      check("ovf_before", overflow, 1'b0);
      check("stalled_valid", outValid, 1'b1);
      startLine();
      check("ovf_set", overflow, 1'b1);
      check("abort_drop", outValid, 1'b0);
      repeat (n1) void'(expQ.pop_front());
      tmp   = expQ.pop_front();
      tmp.f = savedF;
      expQ.push_front(tmp);
      writePix(4, 1'b0); endLine();
      drain("ovf", 3);
      check("ovf_sticky", overflow, 1'b1);

      check("stall_stable", stabBad, 0);
      check("stall_seen", 32'(stabChecks > 0), 1);

      resetN = 1'b0;
      tick();
      check("rst2_ovf", overflow, 1'b0);
      check("rst2_valid", outValid, 1'b0);
      resetN = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
